// File: rtl/busca_decodifica_pkg.sv
// Shared encodings for the fetch/decode stage and the control stage that consumes it.
package busca_decodifica_pkg;

  // Instruction class codes presented on tipo
  localparam logic [2:0] TIPO_LW     = 3'b000;
  localparam logic [2:0] TIPO_SW     = 3'b010;
  localparam logic [2:0] TIPO_R      = 3'b011;
  localparam logic [2:0] TIPO_BEQ    = 3'b110;
  localparam logic [2:0] TIPO_ILEGAL = 3'b111;

  // Supported major opcodes (instr[6:0])
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  // Accepted funct7 values for R-type (base and alternate, e.g. add/sub)
  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  // Fetch/decode FSM encoding
  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_REQ  = 2'b01;
  localparam logic [1:0] ST_OUT  = 2'b10;

endpackage

// File: rtl/busca_decodifica_gerador_imediato.sv
// Immediate generator: builds the sign-extended immediate for the decoded class.
module gerador_imediato
  import busca_decodifica_pkg::*;
(
  input  logic [31:0] instr,
  input  logic [2:0]  tipo,
  output logic [31:0] imm
);

  // Register-field and opcode bits never contribute to an immediate
  logic unused_bits;
  assign unused_bits = ^{instr[19:12], instr[6:0]};

  // Select the immediate layout by instruction class; R-type and illegal give zero
  always_comb begin
    imm = 32'h0000_0000;
    case (tipo)
      TIPO_LW:  imm = {{20{instr[31]}}, instr[31:20]};
      TIPO_SW:  imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      TIPO_BEQ: imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      default:  imm = 32'h0000_0000;
    endcase
  end

endmodule

// File: rtl/busca_decodifica.sv
// Fetch/decode stage: requests one instruction at PC, decodes it into registered
// fields and presents them with a valid/ready handshake. A redirect reloads the
// PC from a branch target and aborts whatever is in flight.
module busca_decodifica
  import busca_decodifica_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_data,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [2:0]  tipo,
  output logic [2:0]  funct3,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [4:0]  rd,
  output logic [31:0] imm,
  output logic [31:0] pc_out,
  output logic        illegal
);

  logic [1:0]  state_q,   state_d;
  logic [31:0] pc_q,      pc_d;
  logic [2:0]  tipo_q,    tipo_d;
  logic [2:0]  funct3_q,  funct3_d;
  logic [4:0]  rs1_q,     rs1_d;
  logic [4:0]  rs2_q,     rs2_d;
  logic [4:0]  rd_q,      rd_d;
  logic [31:0] imm_q,     imm_d;
  logic [31:0] pc_out_q,  pc_out_d;
  logic        illegal_q, illegal_d;

  logic [2:0]  tipo_dec;
  logic        illegal_dec;
  logic [31:0] imm_dec;
  logic [31:0] redirect_al;

  // Branch targets are word aligned; the low two bits are dropped
  assign redirect_al = redirect_pc & 32'hFFFF_FFFC;

  // Classify the incoming word by opcode, with R-type further qualified by funct7
  always_comb begin
    tipo_dec = TIPO_ILEGAL;
    case (imem_data[6:0])
      OP_LW:  tipo_dec = TIPO_LW;
      OP_SW:  tipo_dec = TIPO_SW;
      OP_BEQ: tipo_dec = TIPO_BEQ;
      OP_R: begin
        if ((imem_data[31:25] == F7_BASE) || (imem_data[31:25] == F7_ALT)) begin
          tipo_dec = TIPO_R;
        end
      end
      default: tipo_dec = TIPO_ILEGAL;
    endcase
    illegal_dec = (tipo_dec == TIPO_ILEGAL);
  end

  gerador_imediato u_gerador_imediato (
    .instr (imem_data),
    .tipo  (tipo_dec),
    .imm   (imm_dec)
  );

  // Next-state, PC and decoded-field update; redirect overrides everything else
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    tipo_d    = tipo_q;
    funct3_d  = funct3_q;
    rs1_d     = rs1_q;
    rs2_d     = rs2_q;
    rd_d      = rd_q;
    imm_d     = imm_q;
    pc_out_d  = pc_out_q;
    illegal_d = illegal_q;

    if (redirect) begin
      // Any ack in this cycle is discarded; in OUT a simultaneous out_ready
      // simply means the presented instruction was consumed.
      pc_d    = redirect_al;
      state_d = ST_REQ;
    end else begin
      case (state_q)
        ST_IDLE: state_d = ST_REQ;
        ST_REQ: begin
          if (imem_ack) begin
            tipo_d    = tipo_dec;
            funct3_d  = imem_data[14:12];
            rs1_d     = imem_data[19:15];
            rs2_d     = imem_data[24:20];
            rd_d      = imem_data[11:7];
            imm_d     = imm_dec;
            pc_out_d  = pc_q;
            illegal_d = illegal_dec;
            pc_d      = pc_q + 32'd4;
            state_d   = ST_OUT;
          end
        end
        ST_OUT: begin
          if (out_ready) begin
            state_d = ST_REQ;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State, PC and presented fields; reset aborts any fetch or handshake immediately
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      pc_q      <= RESET_PC;
      tipo_q    <= 3'b000;
      funct3_q  <= 3'b000;
      rs1_q     <= 5'd0;
      rs2_q     <= 5'd0;
      rd_q      <= 5'd0;
      imm_q     <= 32'h0000_0000;
      pc_out_q  <= 32'h0000_0000;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      tipo_q    <= tipo_d;
      funct3_q  <= funct3_d;
      rs1_q     <= rs1_d;
      rs2_q     <= rs2_d;
      rd_q      <= rd_d;
      imm_q     <= imm_d;
      pc_out_q  <= pc_out_d;
      illegal_q <= illegal_d;
    end
  end

  assign imem_req  = (state_q == ST_REQ);
  assign imem_addr = pc_q;
  assign out_valid = (state_q == ST_OUT);
  assign tipo      = tipo_q;
  assign funct3    = funct3_q;
  assign rs1       = rs1_q;
  assign rs2       = rs2_q;
  assign rd        = rd_q;
  assign imm       = imm_q;
  assign pc_out    = pc_out_q;
  assign illegal   = illegal_q;

endmodule

// File: tb/tb_busca_decodifica.sv
// Directed bench for busca_decodifica. A second instance with RESET_PC at the top
// of the address space shares the stimulus to exercise PC wrap-around.
module tb_busca_decodifica;

  logic        clk;
  logic        rst_n;
  logic        imem_ack;
  logic [31:0] imem_data;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        out_ready;

  logic        imem_req,  b_imem_req;
  logic [31:0] imem_addr, b_imem_addr;
  logic        out_valid, b_out_valid;
  logic [2:0]  tipo,      b_tipo;
  logic [2:0]  funct3,    b_funct3;
  logic [4:0]  rs1,       b_rs1;
  logic [4:0]  rs2,       b_rs2;
  logic [4:0]  rd,        b_rd;
  logic [31:0] imm,       b_imm;
  logic [31:0] pc_out,    b_pc_out;
  logic        illegal,   b_illegal;

  int n_checks = 0;
  int n_errors = 0;

  busca_decodifica dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_data(imem_data),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .tipo(tipo), .funct3(funct3), .rs1(rs1), .rs2(rs2), .rd(rd),
    .imm(imm), .pc_out(pc_out), .illegal(illegal)
  );

  busca_decodifica #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk(clk), .rst_n(rst_n),
    .imem_req(b_imem_req), .imem_addr(b_imem_addr),
    .imem_ack(imem_ack), .imem_data(imem_data),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .out_valid(b_out_valid), .out_ready(out_ready),
    .tipo(b_tipo), .funct3(b_funct3), .rs1(b_rs1), .rs2(b_rs2), .rd(b_rd),
    .imm(b_imm), .pc_out(b_pc_out), .illegal(b_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Called at a falling edge while in REQ; returns at the falling edge after the ack edge
  task automatic fetch(input logic [31:0] word, input int waits);
    imem_data = word;
    imem_ack  = 1'b0;
    for (int i = 0; i < waits; i++) begin
      check("wait_req", {31'd0, imem_req}, 32'd1);
      check("wait_valid", {31'd0, out_valid}, 32'd0);
      @(negedge clk);
    end
    check("ack_req", {31'd0, imem_req}, 32'd1);
    imem_ack = 1'b1;
    @(negedge clk);
    imem_ack = 1'b0;
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; imem_ack = 1'b0; imem_data = 32'h0;
    redirect = 1'b0; redirect_pc = 32'h0; out_ready = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_req",     {31'd0, imem_req},  32'd0);
    check("rst_valid",   {31'd0, out_valid}, 32'd0);
    check("rst_tipo",    {29'd0, tipo},      32'd0);
    check("rst_imm",     imm,                32'd0);
    check("rst_pc_out",  pc_out,             32'd0);
    check("rst_illegal", {31'd0, illegal},   32'd0);
    check("rst_addr",    imem_addr,          32'd0);
    check("rst_addr_b",  b_imem_addr,        32'hFFFF_FFFC);

    rst_n = 1'b1;
    @(negedge clk);  // IDLE -> REQ on this edge
    @(negedge clk);
    check("first_req",    {31'd0, imem_req}, 32'd1);
    check("first_addr",   imem_addr,         32'd0);
    check("first_addr_b", b_imem_addr,       32'hFFFF_FFFC);

    // lw x1,0(x0), zero-wait ack
    fetch(32'h0000_2083, 0);
    check("lw_valid",  {31'd0, out_valid}, 32'd1);
    check("lw_tipo",   {29'd0, tipo},      32'd0);
    check("lw_rd",     {27'd0, rd},        32'd1);
    check("lw_imm",    imm,                32'd0);
    check("lw_pc_out", pc_out,             32'd0);
    check("lw_illeg",  {31'd0, illegal},   32'd0);
    check("lw_noreq",  {31'd0, imem_req},  32'd0);
    check("lw_pc_b",   b_pc_out,           32'hFFFF_FFFC);
    consume();
    check("next_addr",   imem_addr,   32'd4);
    check("wrap_addr_b", b_imem_addr, 32'd0);

    // sw x2,-4(x1) after three wait cycles (request held four cycles)
    fetch(32'hFE20_AE23, 3);
    check("sw_valid",  {31'd0, out_valid}, 32'd1);
    check("sw_tipo",   {29'd0, tipo},      32'd2);
    check("sw_imm",    imm,                32'hFFFF_FFFC);
    check("sw_rs1",    {27'd0, rs1},       32'd1);
    check("sw_rs2",    {27'd0, rs2},       32'd2);
    check("sw_funct3", {29'd0, funct3},    32'd2);
    check("sw_pc_out", pc_out,             32'd4);

    // Back-pressure for five cycles; a stray ack in OUT must be ignored
    imem_ack  = 1'b1;
    imem_data = 32'h0000_0013;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold_valid", {31'd0, out_valid}, 32'd1);
      check("hold_req",   {31'd0, imem_req},  32'd0);
      check("hold_tipo",  {29'd0, tipo},      32'd2);
      check("hold_imm",   imm,                32'hFFFF_FFFC);
      check("hold_pc",    pc_out,             32'd4);
      check("hold_ill",   {31'd0, illegal},   32'd0);
    end
    imem_ack = 1'b0;
    consume();
    check("resume_req",  {31'd0, imem_req}, 32'd1);
    check("resume_addr", imem_addr,         32'd8);

    // Redirect in REQ together with an ack: ack discarded, target aligned
    redirect = 1'b1; redirect_pc = 32'h0000_0103;
    imem_ack = 1'b1; imem_data = 32'h0000_2083;
    @(negedge clk);
    redirect = 1'b0; imem_ack = 1'b0;
    check("redir_addr",  imem_addr,         32'h0000_0100);
    check("redir_req",   {31'd0, imem_req}, 32'd1);
    check("redir_valid", {31'd0, out_valid}, 32'd0);
    check("redir_tipo",  {29'd0, tipo},     32'd2);

    // addi: unsupported opcode still presented
    fetch(32'h0000_0013, 1);
    check("addi_tipo",  {29'd0, tipo},      32'd7);
    check("addi_ill",   {31'd0, illegal},   32'd1);
    check("addi_imm",   imm,                32'd0);
    check("addi_valid", {31'd0, out_valid}, 32'd1);
    check("addi_pc",    pc_out,             32'h0000_0100);

    // Redirect with out_ready in OUT
    redirect = 1'b1; redirect_pc = 32'h0000_0200; out_ready = 1'b1;
    @(negedge clk);
    redirect = 1'b0; out_ready = 1'b0;
    check("ro_valid", {31'd0, out_valid}, 32'd0);
    check("ro_req",   {31'd0, imem_req},  32'd1);
    check("ro_addr",  imem_addr,          32'h0000_0200);

    // add x3,x1,x2
    fetch(32'h0020_81B3, 0);
    check("add_tipo", {29'd0, tipo},    32'd3);
    check("add_rd",   {27'd0, rd},      32'd3);
    check("add_rs1",  {27'd0, rs1},     32'd1);
    check("add_rs2",  {27'd0, rs2},     32'd2);
    check("add_imm",  imm,              32'd0);
    check("add_ill",  {31'd0, illegal}, 32'd0);
    check("add_pc",   pc_out,           32'h0000_0200);
    consume();
    check("add_next", imem_addr, 32'h0000_0204);

    // R-type with unsupported funct7
    fetch(32'h0220_81B3, 0);
    check("f7_tipo", {29'd0, tipo},    32'd7);
    check("f7_ill",  {31'd0, illegal}, 32'd1);
    check("f7_imm",  imm,              32'd0);
    consume();

    // beq x0,x0,-4
    fetch(32'hFE00_0EE3, 2);
    check("beqn_tipo", {29'd0, tipo}, 32'd6);
    check("beqn_imm",  imm,           32'hFFFF_FFFC);
    consume();

    // beq x0,x0,+8
    fetch(32'h0000_0463, 0);
    check("beqp_tipo", {29'd0, tipo}, 32'd6);
    check("beqp_imm",  imm,           32'd8);
    consume();

    // lw x1,-4(x1)
    fetch(32'hFFC0_A083, 0);
    check("lwn_tipo",   {29'd0, tipo},   32'd0);
    check("lwn_imm",    imm,             32'hFFFF_FFFC);
    check("lwn_funct3", {29'd0, funct3}, 32'd2);
    check("lwn_pc",     pc_out,          32'h0000_0210);

    // Reset in the middle of a handshake clears everything at once
    out_ready = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    check("arst_valid", {31'd0, out_valid}, 32'd0);
    check("arst_tipo",  {29'd0, tipo},      32'd0);
    check("arst_imm",   imm,                32'd0);
    check("arst_pc",    pc_out,             32'd0);
    check("arst_addr",  imem_addr,          32'd0);
    out_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("rel_req",    {31'd0, imem_req}, 32'd1);
    check("rel_addr",   imem_addr,         32'd0);
    check("rel_addr_b", b_imem_addr,       32'hFFFF_FFFC);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
